// File: rtl/simd_pkg.sv
// Shared widths, instruction format codes and forwarding select encoding
// for the 4-stage SIMD multimedia pipeline.
package simd_pkg;

    localparam int DATA_W  = 128;
    localparam int INSTR_W = 25;
    localparam int ADDR_W  = 5;

    localparam logic [1:0] FMT_R4  = 2'b10;
    localparam logic [1:0] FMT_R3  = 2'b11;
    localparam logic [7:0] OPC_NOP = 8'h00;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_RS1  = 2'b01,
        FWD_RS2  = 2'b10,
        FWD_RS3  = 2'b11
    } fwd_sel_t;

endpackage : simd_pkg

// File: rtl/forwarding_unit_instr_fields.sv
// Combinational instruction decoder: register address fields, whether the
// instruction writes rd, and which source fields name real operands.
module instr_fields
    import simd_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  rd,
    output logic [ADDR_W-1:0]  rs1,
    output logic [ADDR_W-1:0]  rs2,
    output logic [ADDR_W-1:0]  rs3,
    output logic               writes_rd,
    output logic               rs1_v,
    output logic               rs2_v,
    output logic               rs3_v
);

    logic is_r4;
    logic is_r3;

    assign is_r4 = (instr[24:23] == FMT_R4);
    assign is_r3 = (instr[24:23] == FMT_R3);

    assign rd  = instr[4:0];
    assign rs1 = instr[9:5];
    assign rs2 = instr[14:10];
    assign rs3 = instr[19:15];

    // li always writes; an R3 with opcode zero is a nop and writes nothing.
    assign writes_rd = !instr[24] || is_r4 || (is_r3 && (instr[22:15] != OPC_NOP));

    assign rs1_v = is_r4 || is_r3;
    assign rs2_v = is_r4 || is_r3;
    assign rs3_v = is_r4;

endmodule : instr_fields

// File: rtl/forwarding_unit.sv
// WB->EX bypass: selects which EX operand (rs1 > rs2 > rs3) takes the WB
// result, registered for one cycle of latency.
module forwarding_unit
    import simd_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instructionEX,
    input  logic [INSTR_W-1:0] instructionWB,
    input  logic [DATA_W-1:0]  rdWB,
    output logic [1:0]         forward,
    output logic [DATA_W-1:0]  passthrough
);

    logic [ADDR_W-1:0] ex_rd, ex_rs1, ex_rs2, ex_rs3;
    logic              ex_we, ex_rs1_v, ex_rs2_v, ex_rs3_v;
    logic [ADDR_W-1:0] wb_rd, wb_rs1, wb_rs2, wb_rs3;
    logic              wb_we, wb_rs1_v, wb_rs2_v, wb_rs3_v;

    instr_fields u_ex_fields (
        .instr     (instructionEX),
        .rd        (ex_rd),
        .rs1       (ex_rs1),
        .rs2       (ex_rs2),
        .rs3       (ex_rs3),
        .writes_rd (ex_we),
        .rs1_v     (ex_rs1_v),
        .rs2_v     (ex_rs2_v),
        .rs3_v     (ex_rs3_v)
    );

    instr_fields u_wb_fields (
        .instr     (instructionWB),
        .rd        (wb_rd),
        .rs1       (wb_rs1),
        .rs2       (wb_rs2),
        .rs3       (wb_rs3),
        .writes_rd (wb_we),
        .rs1_v     (wb_rs1_v),
        .rs2_v     (wb_rs2_v),
        .rs3_v     (wb_rs3_v)
    );

    // EX destination and WB sources play no part in WB->EX forwarding.
    logic unused_fields;
    assign unused_fields = ^{ex_rd, ex_we, wb_rs1, wb_rs2, wb_rs3,
                             wb_rs1_v, wb_rs2_v, wb_rs3_v};

    logic     hit_rs1, hit_rs2, hit_rs3;
    fwd_sel_t fwd_n;
    logic [DATA_W-1:0] pass_n;

    assign hit_rs1 = wb_we && ex_rs1_v && (ex_rs1 == wb_rd);
    assign hit_rs2 = wb_we && ex_rs2_v && (ex_rs2 == wb_rd);
    assign hit_rs3 = wb_we && ex_rs3_v && (ex_rs3 == wb_rd);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; no latch.
        fwd_n  = FWD_NONE;
        pass_n = '0;
        if (hit_rs1)      fwd_n = FWD_RS1;
        else if (hit_rs2) fwd_n = FWD_RS2;
        else if (hit_rs3) fwd_n = FWD_RS3;
        if (fwd_n != FWD_NONE) pass_n = rdWB;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all registers update together.
        if (!rst_n) begin
            forward     <= FWD_NONE;
            passthrough <= '0;
        end else begin
            forward     <= fwd_n;
            passthrough <= pass_n;
        end
    end

endmodule : forwarding_unit

// File: tb/tb_forwarding_unit.sv
// Directed scoreboard bench for forwarding_unit: expected select/value pushed
// when stimulus is driven, popped and checked one edge later.
module tb_forwarding_unit;
    import simd_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [INSTR_W-1:0] instructionEX;
    logic [INSTR_W-1:0] instructionWB;
    logic [DATA_W-1:0]  rdWB;
    logic [1:0]         forward;
    logic [DATA_W-1:0]  passthrough;

    forwarding_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instructionEX (instructionEX),
        .instructionWB (instructionWB),
        .rdWB          (rdWB),
        .forward       (forward),
        .passthrough   (passthrough)
    );

    always #5 clk = ~clk;

    typedef struct {
        string             tag;
        logic [1:0]        fwd;
        logic [DATA_W-1:0] pass;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_exp;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [INSTR_W-1:0] mk_r3(input logic [7:0] opc, input logic [4:0] s2,
                                                 input logic [4:0] s1, input logic [4:0] d);
        return {FMT_R3, opc, s2, s1, d};
    endfunction

    function automatic logic [INSTR_W-1:0] mk_r4(input logic [4:0] s3, input logic [4:0] s2,
                                                 input logic [4:0] s1, input logic [4:0] d);
        return {FMT_R4, 3'b000, s3, s2, s1, d};
    endfunction

    function automatic logic [INSTR_W-1:0] mk_li(input logic [18:0] imm, input logic [4:0] d);
        return {1'b0, imm, d};
    endfunction

    task automatic check(input string tag, input logic [1:0] f_exp, input logic [DATA_W-1:0] p_exp);
        n_checks++;
        assert (forward === f_exp) else begin
            n_fail++;
            $error("FAIL %s forward: observed %b expected %b", tag, forward, f_exp);
        end
        n_checks++;
        assert (passthrough === p_exp) else begin
            n_fail++;
            $error("FAIL %s passthrough: observed %h expected %h", tag, passthrough, p_exp);
        end
    endtask

    // Drive one cycle of stimulus, confirm outputs hold until the edge,
    // then pop and compare the scoreboard entry after the edge.
    task automatic step(input string tag, input logic rst, input logic [INSTR_W-1:0] ex,
                        input logic [INSTR_W-1:0] wb, input logic [DATA_W-1:0] val,
                        input logic [1:0] f_exp);
        exp_t e;
        rst_n         = rst;
        instructionEX = ex;
        instructionWB = wb;
        rdWB          = val;
        e.tag  = tag;
        e.fwd  = f_exp;
        e.pass = (f_exp != 2'b00) ? val : '0;
        sb_q.push_back(e);
        #1;
        check({tag, "_hold"}, last_exp.fwd, last_exp.pass);
        @(posedge clk);
        #1;
        n_checks++;
        assert (sb_q.size() > 0) else begin
            n_fail++;
            $error("FAIL %s scoreboard: observed empty queue expected an entry", tag);
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.tag, e.fwd, e.pass);
            last_exp = e;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of test expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DATA_W-1:0] six;
        logic [DATA_W-1:0] r;
        six = 128'h00000006_00000006_00000006_00000006;

        rst_n         = 1'b0;
        instructionEX = mk_r3(8'h01, 5'd1, 5'd1, 5'd2);
        instructionWB = mk_r3(8'h01, 5'd3, 5'd4, 5'd1);
        rdWB          = six;
        @(posedge clk);
        #1;
        check("reset_edge1", 2'b00, '0);
        last_exp.tag  = "reset";
        last_exp.fwd  = 2'b00;
        last_exp.pass = '0;
        step("reset_edge2", 1'b0, instructionEX, instructionWB, six, 2'b00);

        // First post-reset edge loads the live rs1 hazard from the inputs above.
        step("post_reset", 1'b1, mk_r3(8'h01, 5'd1, 5'd1, 5'd2), mk_r3(8'h01, 5'd3, 5'd4, 5'd1),
             six, 2'b01);

        step("no_hazard", 1'b1, 25'b1100010001100111110101000, 25'b1100000001011001000111001,
             six, 2'b00);
        step("rs1_hazard", 1'b1, 25'b1100001000010011100101000, 25'b1100000111011001000111001,
             six, 2'b01);
        step("rs2_hazard", 1'b1, 25'b1100000100000010110000100, 25'b1100001011001000110000001,
             six, 2'b10);
        step("rs3_hazard", 1'b1, 25'b1010000001000101000011110, 25'b1100001110001000110000001,
             six, 2'b11);

        r = {$urandom, $urandom, $urandom, $urandom};
        step("wb_nop", 1'b1, mk_r3(8'h01, 5'd2, 5'd7, 5'd9), mk_r3(8'h00, 5'd3, 5'd4, 5'd7),
             r, 2'b00);
        r = {$urandom, $urandom, $urandom, $urandom};
        step("ex_li", 1'b1, mk_li({4'h0, 5'd7, 5'd7, 5'd7}, 5'd7), mk_r3(8'h05, 5'd3, 5'd4, 5'd7),
             r, 2'b00);
        r = {$urandom, $urandom, $urandom, $urandom};
        step("r4_rs1_rs3_prio", 1'b1, mk_r4(5'd5, 5'd6, 5'd5, 5'd20), mk_r3(8'h02, 5'd1, 5'd1, 5'd5),
             r, 2'b01);
        r = {$urandom, $urandom, $urandom, $urandom};
        step("r4_rs2_rs3_prio", 1'b1, mk_r4(5'd6, 5'd6, 5'd5, 5'd20), mk_r3(8'h02, 5'd1, 5'd1, 5'd6),
             r, 2'b10);
        r = {$urandom, $urandom, $urandom, $urandom};
        step("r3_opc_not_rs3", 1'b1, mk_r3({3'b000, 5'd5}, 5'd6, 5'd7, 5'd8),
             mk_r3(8'h02, 5'd1, 5'd1, 5'd5), r, 2'b00);
        r = {$urandom, $urandom, $urandom, $urandom};
        step("r3_rs1_rs2_prio", 1'b1, mk_r3(8'h10, 5'd12, 5'd12, 5'd3), mk_r4(5'd0, 5'd0, 5'd0, 5'd12),
             r, 2'b01);
        r = {$urandom, $urandom, $urandom, $urandom};
        step("wb_li_writes", 1'b1, mk_r3(8'h03, 5'd3, 5'd9, 5'd1), mk_li(19'h7ffff, 5'd3),
             r, 2'b10);
        r = {$urandom, $urandom, $urandom, $urandom};
        step("reg0_hazard", 1'b1, mk_r3(8'h03, 5'd9, 5'd0, 5'd1), mk_r3(8'h04, 5'd2, 5'd2, 5'd0),
             r, 2'b01);
        r = {$urandom, $urandom, $urandom, $urandom};
        step("mid_reset", 1'b0, mk_r4(5'd4, 5'd4, 5'd4, 5'd4), mk_r3(8'h04, 5'd2, 5'd2, 5'd4),
             r, 2'b00);
        r = {$urandom, $urandom, $urandom, $urandom};
        step("after_mid_reset", 1'b1, mk_r4(5'd4, 5'd1, 5'd2, 5'd4), mk_r3(8'h04, 5'd2, 5'd2, 5'd4),
             r, 2'b11);
        step("back_to_none", 1'b1, mk_r3(8'h01, 5'd1, 5'd2, 5'd3), mk_r3(8'h01, 5'd1, 5'd2, 5'd31),
             r, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_forwarding_unit
